// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Round-robin read scheduler draining NUM_SRC FIFO read ports into a single
//   valid/ready consumer in bursts of up to MAX_BURST words per grant.
//   One arbitration cycle (IDLE) precedes each burst. Pops are only issued
//   when the output register has space, so nothing is overwritten and no
//   empty FIFO is ever popped.
//
// Ports
//   rd_clk, rd_rst   read-domain clock, synchronous active-high reset
//   src_empty        per-FIFO registered empty flag
//   src_rd_data      per-FIFO head word, source i at [i*DATA_W +: DATA_W]
//   src_en           per-source arbitration enable mask
//   src_rd_en        per-FIFO pop strobe (combinational, one-hot or zero)
//   out_valid/out_data/out_src  registered output word and its source index
//   out_ready        consumer accept
//   busy             high while a burst is in progress
//
// Optional build macro
//   FIFO_ARB_PRIO0_EN  source 0 wins IDLE selection whenever eligible and does
//                      not move the round-robin pointer. Undefined: pure RR.

module fifo_rd_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        rd_clk,
  input  logic                        rd_rst,
  input  logic [NUM_SRC-1:0]          src_empty,
  input  logic [NUM_SRC*DATA_W-1:0]   src_rd_data,
  input  logic [NUM_SRC-1:0]          src_en,
  output logic [NUM_SRC-1:0]          src_rd_en,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]  out_src,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [GW-1:0]       out_src_q, out_src_d;

  logic [NUM_SRC-1:0]  elig;
  logic                found;
  logic                found_rr;
  logic [GW-1:0]       pick;
  logic                pick_moves_rr;
  logic                g_en, g_empty;
  logic [DATA_W-1:0]   head_data;
  logic                space;
  logic                pop;

  assign elig  = src_en & ~src_empty;
  assign space = ~out_valid_q | out_ready;

  // Round-robin search starting one past the last RR grant.
  always_comb begin
    logic [GW-1:0] idx;
    found_rr      = 1'b0;
    pick          = '0;
    idx           = '0;
    pick_moves_rr = 1'b1;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = GW'((int'(last_grant_q) + k) % NUM_SRC);
      if (!found_rr && elig[idx]) begin
        found_rr = 1'b1;
        pick     = idx;
      end
    end
    found = found_rr;
`ifdef FIFO_ARB_PRIO0_EN
    // Source 0 overrides RR but leaves the RR pointer where it was, so the
    // other sources keep their place in the rotation.
    if (elig[0]) begin
      found         = 1'b1;
      pick          = '0;
      pick_moves_rr = 1'b0;
    end
`endif
  end

  // Granted-source view: enable, empty and head word.
  always_comb begin
    g_en      = 1'b0;
    g_empty   = 1'b1;
    head_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        g_en      = src_en[i];
        g_empty   = src_empty[i];
        head_data = src_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register and datapath flops.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d     = ST_BURST;
          grant_d     = pick;
          burst_cnt_d = '0;
          if (pick_moves_rr) last_grant_d = pick;
        end
      end
      ST_BURST: begin
        if (pop) burst_cnt_d = burst_cnt_q + CW'(1);
        // Losing the source ends the burst without a pop; otherwise the
        // burst ends on the pop that reaches MAX_BURST. Back-pressure just
        // holds here with the count frozen.
        if (!g_en || g_empty)
          state_d = ST_IDLE;
        else if (pop && burst_cnt_q == CW'(MAX_BURST - 1))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pop strobe and output register update.
  always_comb begin
    pop         = (state_q == ST_BURST) & g_en & ~g_empty & space & ~rd_rst;
    busy        = (state_q == ST_BURST);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    for (int i = 0; i < NUM_SRC; i++)
      src_rd_en[i] = pop & (grant_q == GW'(i));
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = head_data;
      out_src_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  a_onehot_rd_en: assert property (@(posedge rd_clk) $onehot0(src_rd_en));
  a_no_empty_pop: assert property (@(posedge rd_clk) (src_rd_en & src_empty) == '0);

endmodule
